// File: rtl/mul_seq_pkg.sv
// Shared types and widths for the multiplier operand sequencer.
package mul_seq_pkg;

  localparam int ACC_W  = 12;
  localparam int CNT_W  = 5;
  localparam int OP_W   = 4;
  localparam int PROD_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MUL,
    ST_ACC,
    ST_HOLD
  } state_t;

  // Packed so that last lands on bit 8, a on [7:4], b on [3:0].
  typedef struct packed {
    logic            last;
    logic [OP_W-1:0] a;
    logic [OP_W-1:0] b;
  } entry_t;

  localparam int ENTRY_W = $bits(entry_t);

endpackage

// File: rtl/op_fifo.sv
// Synchronous FIFO with occupancy count; DEPTH must be a power of two.
module op_fifo #(
  parameter  int DEPTH = 4,
  parameter  int WIDTH = 9,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic             do_push, do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: ;
      endcase
    end
  end

  // NOTE: storage is deliberately not reset; the pointers and count define
  // validity, and leaving it out of reset lets it map onto plain RAM.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

endmodule

// File: rtl/mul_operand_sequencer.sv
// Feeds buffered operand pairs to an external 4x4 multiplier and sums the
// products of each group, emitting the group sum over a valid/ready stream.
module mul_operand_sequencer
  import mul_seq_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int MAX_GROUP  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [OP_W-1:0]   in_a,
  input  logic [OP_W-1:0]   in_b,
  input  logic              in_last,
  output logic [OP_W-1:0]   mul_a,
  output logic [OP_W-1:0]   mul_b,
  input  logic [PROD_W-1:0] mul_p,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [ACC_W-1:0]  out_sum,
  output logic [CNT_W-1:0]  out_count
);

  localparam int FCW = $clog2(FIFO_DEPTH + 1);

  state_t              state;
  logic [OP_W-1:0]     op_a, op_b;
  logic                op_last;
  logic [PROD_W-1:0]   prod_r;
  logic [ACC_W-1:0]    acc;
  logic [CNT_W-1:0]    cnt, cnt_inc;
  entry_t              wr_entry, rd_entry;
  logic                fifo_full, fifo_empty, push, pop;
  logic [FCW-1:0]      fifo_count;

  // Readiness depends only on registered occupancy, so out_ready never
  // reaches in_ready combinationally.
  assign in_ready = rst_n && !fifo_full;
  assign push     = in_valid && in_ready;
  assign pop      = (state == ST_IDLE) && !fifo_empty;
  assign wr_entry = '{last: in_last, a: in_a, b: in_b};
  assign cnt_inc  = cnt + 1'b1;

  op_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (push),
    .pop   (pop),
    .wdata (wr_entry),
    .rdata (rd_entry),
    .full  (fifo_full),
    .empty (fifo_empty),
    .count (fifo_count)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_last <= 1'b0;
      prod_r  <= '0;
      acc     <= '0;
      cnt     <= '0;
    end else begin
      unique case (state)
        ST_IDLE: begin
          if (pop) begin
            op_a    <= rd_entry.a;
            op_b    <= rd_entry.b;
            op_last <= rd_entry.last;
            state   <= ST_MUL;
          end
        end
        // The multiplier gets the whole MUL cycle to settle before capture.
        ST_MUL: begin
          prod_r <= mul_p;
          state  <= ST_ACC;
        end
        ST_ACC: begin
          acc   <= acc + ACC_W'(prod_r);
          cnt   <= cnt_inc;
          state <= (op_last || cnt_inc == CNT_W'(MAX_GROUP)) ? ST_HOLD : ST_IDLE;
        end
        ST_HOLD: begin
          if (out_ready) begin
            acc   <= '0;
            cnt   <= '0;
            state <= ST_IDLE;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

  assign mul_a     = op_a;
  assign mul_b     = op_b;
  assign out_valid = (state == ST_HOLD);
  assign out_sum   = acc;
  assign out_count = cnt;

  // The full flag and the occupancy count must always agree.
  full_matches_count: assert property (@(posedge clk) disable iff (!rst_n)
    fifo_full == (fifo_count == FCW'(FIFO_DEPTH)));

endmodule

// File: tb/tb_mul_operand_sequencer.sv
// Scoreboard bench for mul_operand_sequencer with a behavioural 4x4 multiplier.
module tb_mul_operand_sequencer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_a, in_b;
  logic        in_last;
  logic [3:0]  mul_a, mul_b;
  logic [7:0]  mul_p;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] out_sum;
  logic [4:0]  out_count;

  typedef struct packed {
    logic [11:0] sum;
    logic [4:0]  cnt;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  mul_operand_sequencer #(.FIFO_DEPTH(4), .MAX_GROUP(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_a      (in_a),
    .in_b      (in_b),
    .in_last   (in_last),
    .mul_a     (mul_a),
    .mul_b     (mul_b),
    .mul_p     (mul_p),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_count (out_count)
  );

  assign mul_p = mul_a * mul_b;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic expect_result(input int sum, input int cnt);
    sb.push_back('{sum: 12'(sum), cnt: 5'(cnt)});
  endtask

  task automatic sync();
    @(posedge clk);
    #1;
  endtask

  // Call only just after a rising edge; returns just after the accept edge.
  task automatic push_pair(input logic [3:0] a, input logic [3:0] b, input logic last);
    int guard = 0;
    in_valid = 1'b1;
    in_a     = a;
    in_b     = b;
    in_last  = last;
    @(negedge clk);
    while (!in_ready && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) check("push_timeout", 0, 1);
    sync();
    in_valid = 1'b0;
  endtask

  task automatic drain();
    int guard = 0;
    while (sb.size() != 0 && guard < 500) begin
      @(negedge clk);
      guard++;
    end
    check("drain_pending", sb.size(), 0);
    sync();
  endtask

  // Monitor: pops expected results on each output handshake and checks
  // that a presented result stays put until it is accepted.
  logic        prev_valid = 1'b0;
  logic        prev_hs    = 1'b0;
  logic [11:0] prev_sum   = '0;
  logic [4:0]  prev_cnt   = '0;

  always @(negedge clk) begin
    exp_t e;
    if (!rst_n) begin
      prev_valid = 1'b0;
      prev_hs    = 1'b0;
    end else begin
      if (prev_valid && !prev_hs) begin
        check("hold_valid", out_valid, 1);
        check("hold_sum", out_sum, prev_sum);
        check("hold_count", out_count, prev_cnt);
      end
      if (prev_hs) check("valid_drop", out_valid, 0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL unexpected_result: got sum %0d count %0d, expected none",
                   out_sum, out_count);
        end else begin
          e = sb.pop_front();
          check("result_sum", out_sum, e.sum);
          check("result_count", out_count, e.cnt);
        end
      end
      prev_valid = out_valid;
      prev_hs    = out_valid && out_ready;
      prev_sum   = out_sum;
      prev_cnt   = out_count;
    end
  end

  initial begin
    int guard;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_a      = '0;
    in_b      = '0;
    in_last   = 1'b0;
    out_ready = 1'b1;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_in_ready", in_ready, 0);
    check("rst_mul_a", mul_a, 0);
    check("rst_mul_b", mul_b, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_sum", out_sum, 0);
    check("rst_out_count", out_count, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready", in_ready, 1);
    sync();

    // Single pair 3x5: latency and one-cycle result
    expect_result(15, 1);
    push_pair(4'd3, 4'd5, 1'b1);
    @(negedge clk); check("t1_valid_c1", out_valid, 0);
    @(negedge clk); check("t1_valid_c2", out_valid, 0);
    check("t1_mul_a", mul_a, 3);
    check("t1_mul_b", mul_b, 5);
    @(negedge clk); check("t1_valid_c3", out_valid, 0);
    @(negedge clk); check("t1_valid_c4", out_valid, 1);
    check("t1_sum_c4", out_sum, 15);
    @(negedge clk); check("t1_valid_c5", out_valid, 0);
    sync();

    // Multi-pair group then a single-pair group
    expect_result(451, 4);
    push_pair(4'd15, 4'd15, 1'b0);
    push_pair(4'd15, 4'd15, 1'b0);
    push_pair(4'd1,  4'd1,  1'b0);
    push_pair(4'd0,  4'd9,  1'b1);
    expect_result(14, 1);
    push_pair(4'd2, 4'd7, 1'b1);
    drain();

    // Forced close at 16 products, 17th pair closes on its own last
    expect_result(3600, 16);
    expect_result(225, 1);
    for (int i = 0; i < 16; i++) push_pair(4'd15, 4'd15, 1'b0);
    push_pair(4'd15, 4'd15, 1'b1);
    drain();

    // Output backpressure fills the FIFO; results survive in order
    out_ready = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      expect_result(i * i, 1);
      push_pair(4'(i), 4'(i), 1'b1);
    end
    @(negedge clk);
    check("bp_in_ready_full", in_ready, 0);
    check("bp_out_valid", out_valid, 1);
    check("bp_out_sum_held", out_sum, 1);
    in_valid = 1'b1;
    in_a     = 4'd6;
    in_b     = 4'd6;
    in_last  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_full_push_blocked", in_ready, 0);
    end
    sync();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    drain();

    // Simultaneous push and pop at occupancy 3
    out_ready = 1'b0;
    expect_result(1, 1); push_pair(4'd1, 4'd1, 1'b1);
    expect_result(2, 1); push_pair(4'd1, 4'd2, 1'b1);
    expect_result(3, 1); push_pair(4'd1, 4'd3, 1'b1);
    expect_result(4, 1); push_pair(4'd1, 4'd4, 1'b1);
    guard = 0;
    @(negedge clk);
    while (!out_valid && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    check("pp_wait_valid", out_valid, 1);
    check("pp_occ_before", int'(dut.u_fifo.count), 3);
    sync();
    out_ready = 1'b1;
    @(negedge clk);
    sync();
    expect_result(5, 1);
    in_valid = 1'b1;
    in_a     = 4'd1;
    in_b     = 4'd5;
    in_last  = 1'b1;
    @(negedge clk);
    check("pp_occ_pre_edge", int'(dut.u_fifo.count), 3);
    check("pp_in_ready_pre", in_ready, 1);
    sync();
    in_valid = 1'b0;
    @(negedge clk);
    check("pp_occ_after", int'(dut.u_fifo.count), 3);
    check("pp_in_ready_after", in_ready, 1);
    sync();
    drain();

    // Reset mid-group discards the partial sum
    push_pair(4'd1, 4'd1, 1'b0);
    push_pair(4'd2, 4'd2, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_in_ready", in_ready, 0);
    sync();
    @(negedge clk);
    check("mid_rst_out_valid", out_valid, 0);
    check("mid_rst_out_sum", out_sum, 0);
    check("mid_rst_out_count", out_count, 0);
    check("mid_rst_mul_a", mul_a, 0);
    check("mid_rst_mul_b", mul_b, 0);
    sync();
    rst_n = 1'b1;
    @(negedge clk);
    check("after_rst_in_ready", in_ready, 1);
    sync();
    expect_result(4, 1);
    push_pair(4'd2, 4'd2, 1'b1);
    drain();

    repeat (5) @(negedge clk);
    check("final_scoreboard_empty", sb.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
